// File: rtl/sync_pkt_fifo_pkg.sv
// Shared constants and pointer helpers for the single-clock packet FIFO.
// Pointers carry one extra bit so that full and empty can be told apart.
package sync_pkt_fifo_pkg;

    localparam int c_MAX_DEPTH_WIDTH = 16;
    localparam int c_MAX_PTR_WIDTH   = c_MAX_DEPTH_WIDTH + 1;
    localparam int c_DEF_DEPTH_WIDTH = 10;
    localparam int c_DEF_DEPTH       = 1 << c_DEF_DEPTH_WIDTH;

    typedef logic [c_MAX_PTR_WIDTH-1:0] ptr_max_t;

    function automatic int ptr_width(input int depth_width);
        return depth_width + 1;
    endfunction

    function automatic int depth_of(input int depth_width);
        return 1 << depth_width;
    endfunction

    // Callers truncate the result to their own pointer width, which yields modulo arithmetic.
    function automatic ptr_max_t ptr_diff(input ptr_max_t a, input ptr_max_t b);
        return a - b;
    endfunction

endpackage

// File: rtl/sync_pkt_fifo_if.sv
// Write/read handshake bundle of the packet FIFO; the FIFO itself is the slave.
interface sync_pkt_fifo_if
    import sync_pkt_fifo_pkg::*;
#(
    parameter int c_DEPTH_WIDTH = 10,
    parameter int c_DATA_WIDTH  = 32
);
    localparam int c_PTR_W = ptr_width(c_DEPTH_WIDTH);

    logic                    clr;
    logic [c_DATA_WIDTH-1:0] wr_data;
    logic                    wr_en;
    logic                    wr_commit;
    logic                    wr_discard;
    logic                    wr_full;
    logic                    almost_full;
    logic [c_PTR_W-1:0]      wr_water_level;
    logic                    wr_overflow;
    logic [c_DATA_WIDTH-1:0] rd_data;
    logic                    rd_en;
    logic                    rd_empty;
    logic                    almost_empty;
    logic [c_PTR_W-1:0]      rd_water_level;
    logic                    rd_underflow;

    modport master (
        output clr, wr_data, wr_en, wr_commit, wr_discard, rd_en,
        input  wr_full, almost_full, wr_water_level, wr_overflow,
               rd_data, rd_empty, almost_empty, rd_water_level, rd_underflow
    );

    modport slave (
        input  clr, wr_data, wr_en, wr_commit, wr_discard, rd_en,
        output wr_full, almost_full, wr_water_level, wr_overflow,
               rd_data, rd_empty, almost_empty, rd_water_level, rd_underflow
    );

endinterface

// File: rtl/sync_pkt_fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read with enable.
// Only the read register is reset/cleared; the array itself never is.
module sync_pkt_fifo_ram
    import sync_pkt_fifo_pkg::*;
#(
    parameter int c_ADDR_WIDTH = 10,
    parameter int c_DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    we,
    input  logic [c_ADDR_WIDTH-1:0] waddr,
    input  logic [c_DATA_WIDTH-1:0] wdata,
    input  logic                    re,
    input  logic [c_ADDR_WIDTH-1:0] raddr,
    output logic [c_DATA_WIDTH-1:0] rdata
);
    localparam int c_WORDS = depth_of(c_ADDR_WIDTH);

    logic [c_DATA_WIDTH-1:0] mem_q [c_WORDS];
    logic [c_DATA_WIDTH-1:0] rdata_q;
    logic [c_DATA_WIDTH-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (clr) begin
            rdata_d = '0;
        end else if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_pkt_fifo.sv
// Single-clock FIFO with packet commit/discard, standard or first-word-fall-through
// read, synchronous flush and registered overflow/underflow pulses.
module sync_pkt_fifo
    import sync_pkt_fifo_pkg::*;
#(
    parameter int c_DEPTH_WIDTH      = 10,
    parameter int c_DATA_WIDTH       = 32,
    parameter int c_FWFT             = 0,
    parameter int c_PKT_MODE         = 0,
    parameter int c_ALMOST_FULL_NUM  = 1020,
    parameter int c_ALMOST_EMPTY_NUM = 4
) (
    input logic            clk,
    input logic            rst_n,
    sync_pkt_fifo_if.slave bus
);
    localparam int c_PTR_W = ptr_width(c_DEPTH_WIDTH);

    typedef logic [c_PTR_W-1:0] ptr_t;

    localparam ptr_t c_FULL_LVL = ptr_t'(depth_of(c_DEPTH_WIDTH));
    localparam ptr_t c_AF_LVL   = ptr_t'(c_ALMOST_FULL_NUM);
    localparam ptr_t c_AE_LVL   = ptr_t'(c_ALMOST_EMPTY_NUM);

    function automatic ptr_t level(input ptr_t a, input ptr_t b);
        return ptr_t'(ptr_diff(ptr_max_t'(a), ptr_max_t'(b)));
    endfunction

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t cmt_ptr_q, cmt_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t fetch_ptr_q, fetch_ptr_d;
    logic r_vld_q, r_vld_d;
    logic o_vld_q, o_vld_d;
    logic [c_DATA_WIDTH-1:0] o_data_q, o_data_d;
    logic wr_overflow_q, wr_overflow_d;
    logic rd_underflow_q, rd_underflow_d;

    ptr_t wr_lvl, rd_lvl, wr_ptr_inc;
    logic wr_full, wr_acc, do_commit, do_discard;
    logic rd_empty, pop, r_take, o_take, fetch;
    logic [1:0] occ;
    logic [c_DATA_WIDTH-1:0] rd_data;

    logic                     ram_we, ram_re;
    logic [c_DEPTH_WIDTH-1:0] ram_raddr;
    logic [c_DATA_WIDTH-1:0]  ram_rdata;

    always_comb begin
        wr_lvl     = level(wr_ptr_q, rd_ptr_q);
        rd_lvl     = level(cmt_ptr_q, rd_ptr_q);
        wr_full    = (wr_lvl == c_FULL_LVL);
        wr_acc     = bus.wr_en && !wr_full;
        do_commit  = (c_PKT_MODE != 0) && bus.wr_commit;
        do_discard = (c_PKT_MODE != 0) && bus.wr_discard;
        wr_ptr_inc = wr_ptr_q + ptr_t'(wr_acc);

        // FWFT head lives in the output register when valid, otherwise in the RAM read register.
        if (c_FWFT != 0) begin
            rd_empty = !(o_vld_q || r_vld_q);
            rd_data  = o_vld_q ? o_data_q : ram_rdata;
        end else begin
            rd_empty = (rd_lvl == '0);
            rd_data  = ram_rdata;
        end
        pop    = bus.rd_en && !rd_empty;
        r_take = pop && !o_vld_q;
        o_take = pop && o_vld_q;
        occ    = 2'(o_vld_q) + 2'(r_vld_q) - 2'(pop);
        fetch  = (fetch_ptr_q != cmt_ptr_q) && (occ < 2'd2);

        wr_ptr_d = do_discard ? cmt_ptr_q : wr_ptr_inc;
        if (c_PKT_MODE == 0) begin
            cmt_ptr_d = wr_ptr_inc;
        end else if (do_discard) begin
            cmt_ptr_d = cmt_ptr_q;
        end else if (do_commit) begin
            cmt_ptr_d = wr_ptr_inc;
        end else begin
            cmt_ptr_d = cmt_ptr_q;
        end
        rd_ptr_d    = rd_ptr_q + ptr_t'(pop);
        fetch_ptr_d = fetch_ptr_q + ptr_t'(fetch);

        r_vld_d  = fetch ? 1'b1 : (r_take ? 1'b0 : r_vld_q);
        o_vld_d  = o_vld_q;
        o_data_d = o_data_q;
        // A new fetch overwrites the RAM register, so an unconsumed word there moves forward first.
        if (fetch && r_vld_q && !r_take) begin
            o_vld_d  = 1'b1;
            o_data_d = ram_rdata;
        end else if (o_take) begin
            o_vld_d = 1'b0;
        end

        wr_overflow_d  = bus.wr_en && wr_full;
        rd_underflow_d = bus.rd_en && rd_empty;

        if (bus.clr) begin
            wr_ptr_d       = '0;
            cmt_ptr_d      = '0;
            rd_ptr_d       = '0;
            fetch_ptr_d    = '0;
            r_vld_d        = 1'b0;
            o_vld_d        = 1'b0;
            wr_overflow_d  = 1'b0;
            rd_underflow_d = 1'b0;
        end

        ram_we    = wr_acc && !do_discard && !bus.clr;
        ram_re    = (c_FWFT != 0) ? fetch : pop;
        ram_raddr = (c_FWFT != 0) ? fetch_ptr_q[c_DEPTH_WIDTH-1:0] : rd_ptr_q[c_DEPTH_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            cmt_ptr_q      <= '0;
            rd_ptr_q       <= '0;
            fetch_ptr_q    <= '0;
            r_vld_q        <= 1'b0;
            o_vld_q        <= 1'b0;
            wr_overflow_q  <= 1'b0;
            rd_underflow_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            cmt_ptr_q      <= cmt_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fetch_ptr_q    <= fetch_ptr_d;
            r_vld_q        <= r_vld_d;
            o_vld_q        <= o_vld_d;
            wr_overflow_q  <= wr_overflow_d;
            rd_underflow_q <= rd_underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        o_data_q <= o_data_d;
    end

    sync_pkt_fifo_ram #(
        .c_ADDR_WIDTH (c_DEPTH_WIDTH),
        .c_DATA_WIDTH (c_DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clr),
        .we    (ram_we),
        .waddr (wr_ptr_q[c_DEPTH_WIDTH-1:0]),
        .wdata (bus.wr_data),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign bus.wr_full        = wr_full;
    assign bus.almost_full    = (wr_lvl >= c_AF_LVL);
    assign bus.wr_water_level = wr_lvl;
    assign bus.wr_overflow    = wr_overflow_q;
    assign bus.rd_data        = rd_data;
    assign bus.rd_empty       = rd_empty;
    assign bus.almost_empty   = (rd_lvl <= c_AE_LVL);
    assign bus.rd_water_level = rd_lvl;
    assign bus.rd_underflow   = rd_underflow_q;

endmodule
